// File: rtl/bin_2_bcd.sv
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
// One bit of the operand is consumed per clock; the result appears after IN_WIDTH cycles.
module bin_2_bcd #(
   parameter int IN_WIDTH = 12,
   parameter int DIGITS   = 4
) (
   input  logic                  CLK_i,
   input  logic                  RST_i,
   input  logic                  START_i,
   input  logic [IN_WIDTH-1:0]   IN_i,
   output logic                  BUSY_o,
   output logic                  DONE_o,
   output logic [4*DIGITS-1:0]   OUT_o
);

   localparam int ACC_W  = 4 * DIGITS;
   localparam int WIDE_W = ACC_W + IN_WIDTH;
   localparam int CNT_W  = $clog2(IN_WIDTH + 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_e;

   state_e              state_q, state_d;
   logic [IN_WIDTH-1:0] bin_q, bin_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ACC_W-1:0]    out_q, out_d;
   logic                done_q, done_d;

   logic [ACC_W-1:0]    adjusted;
   logic [WIDE_W-1:0]   wide;
   logic [WIDE_W-1:0]   wideShift;

   // Digits >= 5 get +3 so the following doubling carries correctly into the next decade.
   always_comb begin
      adjusted = acc_q;
      for (int d = 0; d < DIGITS; d++) begin
         if (acc_q[4*d +: 4] >= 4'd5) begin
            adjusted[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
         end
      end
      wide      = {adjusted, bin_q};
      wideShift = wide << 1;
   end

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (START_i) begin
               bin_d   = IN_i;
               acc_d   = '0;
               cnt_d   = CNT_W'(IN_WIDTH);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            acc_d = wideShift[WIDE_W-1:IN_WIDTH];
            bin_d = wideShift[IN_WIDTH-1:0];
            cnt_d = cnt_q - CNT_W'(1);
            // Last shift publishes straight from the shifter so OUT_o never shows partial values.
            if (cnt_q == CNT_W'(1)) begin
               out_d   = wideShift[WIDE_W-1:IN_WIDTH];
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK_i) begin
      if (RST_i) begin
         state_q <= IDLE;
         bin_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         out_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         done_q  <= done_d;
      end
   end

   assign BUSY_o = (state_q == SHIFT);
   assign DONE_o = done_q;
   assign OUT_o  = out_q;

endmodule

// File: tb/tb_bin_2_bcd.sv
// Scoreboard bench for bin_2_bcd: stimulus pushes expected results with their due cycle,
// a negedge monitor pops and compares on every DONE_o pulse.
module tb_bin_2_bcd;

   localparam int IN_WIDTH = 12;
   localparam int DIGITS   = 4;

   typedef struct {
      logic [15:0] value;
      int          due;
   } sbEntry;

   logic                CLK_i;
   logic                RST_i;
   logic                START_i;
   logic [IN_WIDTH-1:0] IN_i;
   logic                BUSY_o;
   logic                DONE_o;
   logic [15:0]         OUT_o;

   sbEntry sbQ[$];
   sbEntry popped;
   int     cycleCnt;
   int     checks;
   int     failures;

   bin_2_bcd #(.IN_WIDTH(IN_WIDTH), .DIGITS(DIGITS)) dut (
      .CLK_i  (CLK_i),
      .RST_i  (RST_i),
      .START_i(START_i),
      .IN_i   (IN_i),
      .BUSY_o (BUSY_o),
      .DONE_o (DONE_o),
      .OUT_o  (OUT_o)
   );

   initial CLK_i = 1'b0;
   always #5 CLK_i = ~CLK_i;

   initial cycleCnt = 0;
   always @(posedge CLK_i) cycleCnt <= cycleCnt + 1;

   // Decimal reference built by division, independent of the shift-and-add structure.
   function automatic logic [15:0] toBcd(input int v);
      logic [15:0] r;
      int          x;
      r = '0;
      x = v;
      for (int d = 0; d < DIGITS; d++) begin
         r[4*d +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycleCnt);
      end
   endtask

   // Issue one START pulse; the entry is pushed only when the DUT is known to accept it.
   task automatic applyStimulus(input int v, input logic [15:0] exp, input bit expectAccept);
      sbEntry e;
      START_i = 1'b1;
      IN_i    = IN_WIDTH'(v);
      @(posedge CLK_i);
      #1;
      START_i = 1'b0;
      IN_i    = ~IN_WIDTH'(v);
      if (expectAccept) begin
         e.value = exp;
         e.due   = cycleCnt + IN_WIDTH;
         sbQ.push_back(e);
      end
   endtask

   task automatic waitDrain();
      for (int i = 0; i < 4 * IN_WIDTH; i++) begin
         if (sbQ.size() == 0) break;
         @(negedge CLK_i);
      end
      if (sbQ.size() != 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL drain_timeout: pending=%0d expected 0", sbQ.size());
         sbQ.delete();
      end
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(negedge CLK_i);
   endtask

   // Monitor: every DONE_o must match the oldest pending expectation, on its due cycle.
   always @(negedge CLK_i) begin
      if (DONE_o === 1'b1) begin
         if (sbQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_done: got DONE_o=1 with OUT_o=%0h expected no pulse", OUT_o);
         end else begin
            popped = sbQ.pop_front();
            checkOutput("latency", cycleCnt, popped.due);
            checkOutput("result", OUT_o, popped.value);
            checkOutput("digit_range",
                        {31'd0, (OUT_o[3:0] <= 4'd9) && (OUT_o[7:4] <= 4'd9) &&
                                (OUT_o[11:8] <= 4'd9) && (OUT_o[15:12] <= 4'd9)},
                        32'd1);
         end
      end else if (sbQ.size() > 0 && sbQ[0].due < cycleCnt) begin
         checks++;
         failures++;
         $display("[TB] FAIL missing_done: no pulse by cycle %0d expected at %0d value %0h",
                  cycleCnt, sbQ[0].due, sbQ[0].value);
         void'(sbQ.pop_front());
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int v;
      checks   = 0;
      failures = 0;
      RST_i    = 1'b1;
      START_i  = 1'b0;
      IN_i     = '0;

      $display("[TB] reset and idle");
      repeat (2) @(posedge CLK_i);
      #1;
      RST_i = 1'b0;
      checkOutput("reset_out", OUT_o, 16'h0000);
      checkOutput("reset_busy", BUSY_o, 1'b0);
      checkOutput("reset_done", DONE_o, 1'b0);
      IN_i = 12'd1234;
      idleCycles(5);
      checkOutput("idle_busy", BUSY_o, 1'b0);
      checkOutput("idle_out", OUT_o, 16'h0000);

      $display("[TB] basic values");
      applyStimulus(1234, 16'h1234, 1'b1);
      checkOutput("busy_after_start", BUSY_o, 1'b1);
      waitDrain();
      applyStimulus(0, 16'h0000, 1'b1);
      waitDrain();
      applyStimulus(10, 16'h0010, 1'b1);
      waitDrain();
      applyStimulus(999, 16'h0999, 1'b1);
      waitDrain();
      applyStimulus(4095, 16'h4095, 1'b1);
      waitDrain();
      idleCycles(1);
      checkOutput("hold_out", OUT_o, 16'h4095);
      checkOutput("busy_cleared", BUSY_o, 1'b0);

      $display("[TB] busy protection");
      applyStimulus(500, 16'h0500, 1'b1);
      repeat (4) @(posedge CLK_i);
      #1;
      applyStimulus(77, 16'h0077, 1'b0);
      checkOutput("busy_during", BUSY_o, 1'b1);
      waitDrain();
      idleCycles(2 * IN_WIDTH);
      checkOutput("busy_protect_out", OUT_o, 16'h0500);

      $display("[TB] back to back");
      applyStimulus(2048, 16'h2048, 1'b1);
      repeat (IN_WIDTH) @(posedge CLK_i);
      #1;
      applyStimulus(3000, 16'h3000, 1'b1);
      waitDrain();
      idleCycles(2);

      $display("[TB] reset mid conversion");
      applyStimulus(4000, 16'h4000, 1'b1);
      repeat (5) @(posedge CLK_i);
      #1;
      RST_i = 1'b1;
      @(posedge CLK_i);
      #1;
      RST_i = 1'b0;
      sbQ.delete();
      checkOutput("abort_out", OUT_o, 16'h0000);
      checkOutput("abort_busy", BUSY_o, 1'b0);
      checkOutput("abort_done", DONE_o, 1'b0);
      idleCycles(2 * IN_WIDTH);
      checkOutput("abort_out_hold", OUT_o, 16'h0000);
      applyStimulus(4000, 16'h4000, 1'b1);
      waitDrain();

      $display("[TB] random sweep");
      for (int i = 0; i < 1000; i++) begin
         v = int'($urandom_range(0, 4095));
         applyStimulus(v, toBcd(v), 1'b1);
         waitDrain();
      end
      idleCycles(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bin_2_bcd.md
Name: bin_2_bcd

Overview:
Sequential binary-to-BCD converter using the iterative shift-and-add-3 (double-dabble) algorithm. It accepts an unsigned binary word on a start strobe and produces packed BCD digits after a fixed latency. It sits between binary datapath logic and the downstream BCD-to-7-segment decoding. The default build is 12-bit binary input and 4 BCD digits.

Parameters:
IN_WIDTH, 12, binary input width in bits; must be >= 1.
DIGITS, 4, number of BCD output digits; must satisfy 10^DIGITS > 2^IN_WIDTH - 1.

Ports:
CLK_i  input  1  clock; all state updates on the rising edge.
RST_i  input  1  reset, synchronous, active-high.
START_i  input  1  conversion request, sampled only in IDLE.
IN_i  input  IN_WIDTH  unsigned binary operand, captured when START_i is accepted.
BUSY_o  output  1  high while a conversion is in progress.
DONE_o  output  1  one-cycle pulse when OUT_o is updated.
OUT_o  output  4*DIGITS  packed BCD result. [3:0] = units, [7:4] = tens, [11:8] = hundreds, [15:12] = thousands, etc.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: with RST_i high at a rising edge, the following take effect at that edge:
  - state returns to IDLE;
  - OUT_o = 0, BUSY_o = 0, DONE_o = 0;
  - internal shift and count registers are cleared.
- Reset overrides every other input, and a reset mid-conversion aborts the conversion with no DONE_o.
- States: IDLE and SHIFT.
- IDLE:
  - If START_i = 1 at edge k, IN_i is captured into the binary shift register.
  - The BCD accumulator is cleared and the shift counter is loaded with IN_WIDTH.
  - BUSY_o goes 1 and the state goes to SHIFT.
  - If START_i = 0, nothing changes.
- SHIFT, one step per edge:
  - Each 4-bit accumulator digit >= 5 has 3 added to it.
  - The concatenated {accumulator, binary} is then shifted left one bit, bringing the binary MSB into the accumulator LSB.
  - The counter decrements.
- Final step: on the edge that performs the IN_WIDTH-th shift (edge k+IN_WIDTH), the following happen together:
  - the shifted accumulator is written to OUT_o;
  - DONE_o = 1 for exactly that following cycle;
  - BUSY_o = 0;
  - state returns to IDLE.
- Latency is exactly IN_WIDTH cycles from START acceptance to the DONE_o pulse.
- OUT_o holds its last result until the next DONE_o. It never shows intermediate values.
- START_i while BUSY_o = 1 is ignored. IN_i changes during a conversion have no effect.
- Back-to-back: START_i high in the cycle DONE_o is high is accepted (the state is IDLE), so the next result follows IN_WIDTH cycles later.
- Arithmetic: the input is unsigned, and every value 0..2^IN_WIDTH-1 must produce a correct decimal representation. Each output digit is always 0..9, and unused leading digits are 0.
- The design has no combinational path from inputs to outputs. All outputs are registered.

Test Plan:
- Reset then idle: assert RST_i for 2 cycles → OUT_o = 0x0000, BUSY_o = 0, DONE_o = 0; no activity while START_i = 0.
- Basic values: START with IN_i = 1234 → after exactly 12 cycles DONE_o pulses once and OUT_o = 16'h1234. Repeat with 0 → 16'h0000, 10 → 16'h0010, 999 → 16'h0999, 4095 → 16'h4095.
- Busy protection: START with IN_i = 500, then pulse START with IN_i = 77 at cycle 5 → a single DONE_o at cycle 12 with OUT_o = 16'h0500; no second conversion occurs.
- Back-to-back: START with 2048, then hold START with IN_i = 3000 during the DONE cycle → OUT_o = 16'h2048, then 12 cycles later OUT_o = 16'h3000.
- Reset mid-operation: START with IN_i = 4000 and assert RST_i at cycle 6 → no DONE_o, OUT_o = 0, BUSY_o = 0. A fresh START with 4000 then yields 16'h4000.
- Random sweep: 1000 random 12-bit inputs, each waiting for DONE_o → OUT_o digits equal the decimal digits of IN_i and every nibble is <= 9.
